// File: rtl/uart_tx_device.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_device
// Purpose  : Memory-mapped 8N1 UART transmitter for the simple-system bus.
//            Bytes written to TXDATA are queued in a FIFO and sent on tx_o.
//            A level interrupt is raised once the FIFO and the shifter have
//            both drained.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_device #(
  parameter int unsigned FifoDepth    = 8,
  parameter logic [15:0] ClkPerBitRst = 16'd434
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        tx_o,
  output logic        irq_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned     c_ptr_w = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [c_ptr_w:0] c_depth = FifoDepth[c_ptr_w:0];

  // Word offsets within the 1 kB window
  localparam logic [7:0] c_idx_txdata = 8'd0;
  localparam logic [7:0] c_idx_status = 8'd1;
  localparam logic [7:0] c_idx_baud   = 8'd2;
  localparam logic [7:0] c_idx_ctrl   = 8'd3;

  // Transmit state encoding
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic               r_rvalid;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic               r_irq;
  logic [15:0]        r_bauddiv;
  logic               r_irq_en;
  logic               r_ovf;

  logic [7:0]         r_mem [FifoDepth];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  logic [1:0]         r_state;
  logic [2:0]         r_bit;
  logic [15:0]        r_baud;
  logic [15:0]        r_div;
  logic [7:0]         r_shift;
  logic               r_tx;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic [7:0]         w_idx;
  logic               w_sel_txdata;
  logic               w_sel_status;
  logic               w_sel_baud;
  logic               w_sel_ctrl;
  logic               w_sel_valid;
  logic               w_push_req;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_busy;
  logic [31:0]        w_rd_mux;
  logic [15:0]        w_div_eff;
  logic               w_bit_end;

  logic [1:0]         w_state_next;
  logic [2:0]         w_bit_next;
  logic [15:0]        w_baud_next;
  logic [15:0]        w_div_next;
  logic [7:0]         w_shift_next;
  logic               w_tx_next;

  // Address bits outside [9:2], upper write data and upper byte enables are
  // intentionally ignored; the window decode is done by the bus fabric.
  logic               w_unused_ok;
  assign w_unused_ok = &{1'b0, addr_i[31:10], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

  // --------------------------------------------------------------------------
  // Address decode and FIFO flags
  // --------------------------------------------------------------------------
  assign w_idx        = addr_i[9:2];
  assign w_sel_txdata = req_i & (w_idx == c_idx_txdata);
  assign w_sel_status = req_i & (w_idx == c_idx_status);
  assign w_sel_baud   = req_i & (w_idx == c_idx_baud);
  assign w_sel_ctrl   = req_i & (w_idx == c_idx_ctrl);
  assign w_sel_valid  = w_sel_txdata | w_sel_status | w_sel_baud | w_sel_ctrl;

  assign w_full       = (r_count == c_depth);
  assign w_empty      = (r_count == '0);
  // Full is judged on the pre-edge occupancy, so a same-cycle pop never
  // makes room for a push.
  assign w_push_req   = w_sel_txdata & we_i & be_i[0];
  assign w_push       = w_push_req & ~w_full;

  // A programmed divider of 0 behaves like 1
  assign w_div_eff    = (r_bauddiv == 16'd0) ? 16'd1 : r_bauddiv;
  assign w_bit_end    = (r_baud == (r_div - 16'd1));

  // Read-data multiplexer for the register map
  always_comb begin
    w_rd_mux = 32'd0;
    case (w_idx)
      c_idx_status: w_rd_mux = {28'd0, r_ovf, w_busy, w_empty, w_full};
      c_idx_baud:   w_rd_mux = {16'd0, r_bauddiv};
      c_idx_ctrl:   w_rd_mux = {31'd0, r_irq_en};
      default:      w_rd_mux = 32'd0;
    endcase
  end

  // Bus response, control registers, sticky overflow and interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
      r_bauddiv <= ClkPerBitRst;
      r_irq_en  <= 1'b0;
      r_ovf     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_rvalid <= req_i;
      r_err    <= req_i & ~w_sel_valid;
      r_rdata  <= (req_i & ~we_i) ? w_rd_mux : 32'd0;

      if (w_sel_status & we_i & wdata_i[3]) begin
        r_ovf <= 1'b0;
      end else if (w_push_req & w_full) begin
        r_ovf <= 1'b1;
      end

      if (w_sel_baud & we_i) begin
        if (be_i[0]) r_bauddiv[7:0]  <= wdata_i[7:0];
        if (be_i[1]) r_bauddiv[15:8] <= wdata_i[15:8];
      end

      if (w_sel_ctrl & we_i & be_i[0]) begin
        r_irq_en <= wdata_i[0];
      end

      r_irq <= r_irq_en & w_empty & (r_state == c_st_idle);
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata_i[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------

  // State register together with the sequencing counters and the tx flop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_st_idle;
      r_bit   <= 3'd0;
      r_baud  <= 16'd0;
      r_div   <= 16'd1;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_bit   <= w_bit_next;
      r_baud  <= w_baud_next;
      r_div   <= w_div_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  // Next-state logic: a pop latches the byte and a snapshot of the divider
  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit;
    w_baud_next  = r_baud;
    w_div_next   = r_div;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_div_next   = w_div_eff;
          w_baud_next  = 16'd0;
          w_bit_next   = 3'd0;
          w_state_next = c_st_start;
        end
      end
      c_st_start: begin
        if (w_bit_end) begin
          w_baud_next  = 16'd0;
          w_bit_next   = 3'd0;
          w_state_next = c_st_data;
        end else begin
          w_baud_next  = r_baud + 16'd1;
        end
      end
      c_st_data: begin
        if (w_bit_end) begin
          w_baud_next = 16'd0;
          if (r_bit == 3'd7) begin
            w_state_next = c_st_stop;
          end else begin
            w_bit_next   = r_bit + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end
      c_st_stop: begin
        if (w_bit_end) begin
          // Chain straight into the next frame when more data is queued
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rd_ptr];
            w_div_next   = w_div_eff;
            w_baud_next  = 16'd0;
            w_bit_next   = 3'd0;
            w_state_next = c_st_start;
          end else begin
            w_baud_next  = 16'd0;
            w_state_next = c_st_idle;
          end
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // Output logic: line level for the upcoming cycle, and the busy flag
  always_comb begin
    w_tx_next = 1'b1;
    w_busy    = (r_state != c_st_idle);
    case (w_state_next)
      c_st_start: w_tx_next = 1'b0;
      c_st_data:  w_tx_next = w_shift_next[w_bit_next];
      default:    w_tx_next = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign tx_o     = r_tx;
  assign irq_o    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_device
// Purpose  : Self-checking bench for uart_tx_device. A frame-level model
//            (byte queue plus a position counter within the current frame)
//            predicts every output each cycle; directed literal checks pin
//            the model to hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_device;

  localparam int DEPTH = 8;

  localparam logic [31:0] c_a_txdata = 32'h0004_0000;
  localparam logic [31:0] c_a_status = 32'h0004_0004;
  localparam logic [31:0] c_a_baud   = 32'h0004_0008;
  localparam logic [31:0] c_a_ctrl   = 32'h0004_000C;
  localparam logic [31:0] c_a_bad    = 32'h0004_0010;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        tx_o;
  logic        irq_o;

  always #5 clk = ~clk;

  uart_tx_device #(
    .FifoDepth   (DEPTH),
    .ClkPerBitRst(16'd434)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .we_i    (we_i),
    .be_i    (be_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .tx_o    (tx_o),
    .irq_o   (irq_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: byte queue, sticky flags, and the active frame as a
  // 10-bit word {stop, data, start} indexed by (cycle_in_frame / divider).
  // --------------------------------------------------------------------------
  logic [7:0]  mq[$];
  logic        m_active;
  int          m_t;
  int          m_div;
  logic [9:0]  m_frame;
  logic [15:0] m_baud;
  logic        m_ctrl;
  logic        m_ovf;
  logic        e_rvalid, e_err, e_tx, e_irq;
  logic [31:0] e_rdata;

  // Model advance on each active edge, using pre-edge inputs and state
  always @(posedge clk) begin
    logic pre_full, pre_empty, pre_busy, do_push;
    logic [7:0] b;
    if (rst_i) begin
      mq.delete();
      m_active = 1'b0; m_t = 0; m_div = 1; m_frame = 10'h3FF;
      m_baud = 16'd434; m_ctrl = 1'b0; m_ovf = 1'b0;
      e_rvalid = 1'b0; e_rdata = 32'd0; e_err = 1'b0; e_tx = 1'b1; e_irq = 1'b0;
    end else begin
      pre_full  = (mq.size() == DEPTH);
      pre_empty = (mq.size() == 0);
      pre_busy  = m_active;
      do_push   = 1'b0;

      e_irq = m_ctrl & pre_empty & ~pre_busy;

      // Frame engine: starts use the divider value before any bus write
      if (!m_active || (m_t == 10 * m_div - 1)) begin
        if (!pre_empty) begin
          b = mq.pop_front();
          m_frame = {1'b1, b, 1'b0};
          m_div = (m_baud == 16'd0) ? 1 : int'(m_baud);
          m_t = 0;
          m_active = 1'b1;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_t++;
      end

      // Bus access
      e_rvalid = req_i; e_rdata = 32'd0; e_err = 1'b0;
      if (req_i) begin
        case (addr_i[9:2])
          8'd0: if (we_i && be_i[0]) do_push = 1'b1;
          8'd1: begin
            if (!we_i) e_rdata = {28'd0, m_ovf, pre_busy, pre_empty, pre_full};
            else if (wdata_i[3]) m_ovf = 1'b0;
          end
          8'd2: begin
            if (!we_i) e_rdata = {16'd0, m_baud};
            else begin
              if (be_i[0]) m_baud[7:0]  = wdata_i[7:0];
              if (be_i[1]) m_baud[15:8] = wdata_i[15:8];
            end
          end
          8'd3: begin
            if (!we_i) e_rdata = {31'd0, m_ctrl};
            else if (be_i[0]) m_ctrl = wdata_i[0];
          end
          default: e_err = 1'b1;
        endcase
      end
      if (do_push) begin
        if (pre_full) m_ovf = 1'b1;
        else mq.push_back(wdata_i[7:0]);
      end

      e_tx = m_active ? m_frame[m_t / m_div] : 1'b1;
    end
  end

  // Compare process: outputs checked mid-cycle on every cycle
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rvalid", {31'd0, rvalid_o}, {31'd0, e_rvalid});
      if (e_rvalid) begin
        chk("rdata", rdata_o, e_rdata);
        chk("err", {31'd0, err_o}, {31'd0, e_err});
      end
      chk("tx", {31'd0, tx_o}, {31'd0, e_tx});
      chk("irq", {31'd0, irq_o}, {31'd0, e_irq});
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the active edge)
  // --------------------------------------------------------------------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] d);
    req_i = 1'b1; we_i = we; be_i = be; addr_i = a; wdata_i = d;
    sync();
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'd0; wdata_i = 32'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, 4'hF, a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    issue(1'b0, 4'hF, a, 32'd0);
    d = rdata_o;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic pulse_rst();
    rst_i = 1'b1;
    sync();
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic [9:0]  fr;
    int          op;

    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'd0; wdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_i  = 1'b0;
    chk_on = 1'b1;

    // 1: reset state
    chk("reset_tx", {31'd0, tx_o}, 32'd1);
    chk("reset_irq", {31'd0, irq_o}, 32'd0);
    rd(c_a_status, v); chk("reset_status", v, 32'h2);
    rd(c_a_baud, v);   chk("reset_bauddiv", v, 32'd434);

    // 2: single 0xA5 frame at 4 clocks per bit
    wr(c_a_baud, 32'd4);
    wr(c_a_txdata, 32'hA5);
    chk("t2_tx_before_start", {31'd0, tx_o}, 32'd1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      sync();
      chk($sformatf("t2_bit%0d_first", k), {31'd0, tx_o}, {31'd0, fr[k]});
      idle(3);
      chk($sformatf("t2_bit%0d_last", k), {31'd0, tx_o}, {31'd0, fr[k]});
    end
    sync();
    chk("t2_tx_after_frame", {31'd0, tx_o}, 32'd1);
    rd(c_a_status, v); chk("t2_status_idle", v, 32'h2);

    // 3: nine back-to-back bytes fit because the first pops early
    wr(c_a_baud, 32'd2);
    for (int k = 0; k < 9; k++) wr(c_a_txdata, 32'h30 + k);
    rd(c_a_status, v); chk("t3_no_overflow", v & 32'h8, 32'h0);
    idle(9 * 20 + 10);
    wr(c_a_baud, 32'd50);
    wr(c_a_txdata, 32'h3C);
    idle(4);
    for (int k = 0; k < 10; k++) wr(c_a_txdata, 32'h40 + k);
    rd(c_a_status, v); chk("t3_status_full_ovf", v, 32'hD);
    wr(c_a_status, 32'h8);
    rd(c_a_status, v); chk("t3_status_ovf_clear", v, 32'h5);
    pulse_rst();
    rd(c_a_status, v); chk("t3_status_flushed", v, 32'h2);

    // 4: interrupt around one frame
    wr(c_a_baud, 32'd3);
    wr(c_a_ctrl, 32'd1);
    idle(2);
    chk("t4_irq_idle", {31'd0, irq_o}, 32'd1);
    wr(c_a_txdata, 32'h5A);
    idle(10);
    chk("t4_irq_in_frame", {31'd0, irq_o}, 32'd0);
    idle(30);
    chk("t4_irq_done", {31'd0, irq_o}, 32'd1);
    wr(c_a_ctrl, 32'd0);
    sync();
    chk("t4_irq_disabled", {31'd0, irq_o}, 32'd0);

    // 5: bad offset, and a zero divider giving single-cycle bits
    rd(c_a_bad, v);
    chk("t5_err", {31'd0, err_o}, 32'd1);
    chk("t5_rdata", v, 32'd0);
    wr(c_a_baud, 32'd0);
    wr(c_a_txdata, 32'h96);
    idle(15);
    chk("t5_tx_idle_after", {31'd0, tx_o}, 32'd1);

    // 6: reset during data bit 3 of an all-zero byte
    wr(c_a_baud, 32'd4);
    wr(c_a_txdata, 32'h00);
    idle(18);
    chk("t6_tx_low_bit3", {31'd0, tx_o}, 32'd0);
    pulse_rst();
    chk("t6_tx_after_reset", {31'd0, tx_o}, 32'd1);
    rd(c_a_status, v); chk("t6_status", v, 32'h2);
    idle(60);
    chk("t6_tx_quiet", {31'd0, tx_o}, 32'd1);

    // Randomised traffic checked by the model
    for (int i = 0; i < 2500; i++) begin
      op = $urandom_range(0, 99);
      if (op < 40) begin
        issue(1'b1, 4'($urandom_range(0, 15)) | 4'h1, c_a_txdata, $urandom);
      end else if (op < 42) begin
        issue(1'b1, 4'($urandom_range(0, 15)), c_a_txdata, $urandom);
      end else if (op < 52) begin
        issue($urandom_range(0, 3) == 0, 4'hF, 32'h0004_0000 | (32'($urandom_range(0, 6)) << 2), $urandom);
      end else if (op < 59) begin
        issue(1'b1, 4'($urandom_range(0, 15)), c_a_baud, {$urandom, 14'd0, 2'($urandom_range(0, 3))} >> 14);
      end else if (op < 64) begin
        issue(1'b1, 4'hF, c_a_status, $urandom);
      end else if (op < 69) begin
        issue(1'b1, 4'($urandom_range(0, 15)), c_a_ctrl, $urandom);
      end else if (op < 70) begin
        pulse_rst();
      end else begin
        idle($urandom_range(0, 30));
      end
    end
    idle(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
